// File: rtl/serial_transmit_if.sv
// Parallel byte handshake into the serial transmitter.
// A byte moves on a rising edge where data_valid and data_ready are both high; the master holds data_in until then.
interface serial_transmit_if;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;

  modport master (
    output data_in,
    output data_valid,
    input  data_ready
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output data_ready
  );
endinterface

// File: rtl/serial_transmit.sv
// Serial transmitter: start bit, 8 data bits MSB first, STOP_BITS stop bits.
// One-entry holding register plus shift register gives back-to-back frames with no idle gap.
module serial_transmit #(
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic               clk,
  input  logic               rst,
  serial_transmit_if.slave   up,
  output logic               txd,
  output logic               busy,
  output logic               frame_done,
  output logic [1:0]         state_o
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    hold_q, hold_d;
  logic          hold_full_q, hold_full_d;
  logic          txd_q, txd_d;
  logic          done_q, done_d;
  logic          bit_end;
  logic          accept;

  assign up.data_ready = ~hold_full_q;
  assign txd           = txd_q;
  assign busy          = (state_q != IDLE);
  assign frame_done    = done_q;
  assign state_o       = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      baud_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      txd_q       <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      txd_q       <= txd_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    txd_d       = txd_q;
    done_d      = 1'b0;
    bit_end     = (baud_q == BAUD_LAST);
    accept      = up.data_valid & ~hold_full_q;

    // Accept and hold->shift transfer are mutually exclusive: one needs hold empty, the other hold full.
    if (accept) begin
      hold_d      = up.data_in;
      hold_full_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (hold_full_q) begin
          shift_d     = hold_q;
          hold_full_d = 1'b0;
          state_d     = START;
          txd_d       = 1'b0;
        end
      end

      START: begin
        if (bit_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
          txd_d   = shift_q[7];
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end

      DATA: begin
        if (bit_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            state_d = STOP;
            txd_d   = 1'b1;
          end else begin
            shift_d = {shift_q[6:0], 1'b0};
            txd_d   = shift_q[6];
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end

      STOP: begin
        // bit_cnt counts stop bits here so two stop bits need no wider counter.
        if (bit_end) begin
          baud_d = '0;
          if (bit_q == STOP_LAST) begin
            bit_d  = '0;
            done_d = 1'b1;
            if (hold_full_q) begin
              shift_d     = hold_q;
              hold_full_d = 1'b0;
              state_d     = START;
              txd_d       = 1'b0;
            end else begin
              state_d = IDLE;
              txd_d   = 1'b1;
            end
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end

      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_transmit.sv
// Directed bench for serial_transmit: a 4-clk/bit one-stop instance and a 16-clk/bit two-stop instance.
module tb_serial_transmit;

  logic clk;
  logic rst;
  logic txd_a, busy_a, done_a;
  logic txd_b, busy_b, done_b;
  logic [1:0] state_a, state_b;

  int checks;
  int errors;
  logic [7:0] exp_q[$];

  serial_transmit_if if_a ();
  serial_transmit_if if_b ();

  serial_transmit #(.CLKS_PER_BIT(4), .STOP_BITS(1)) u_a (
    .clk        (clk),
    .rst        (rst),
    .up         (if_a),
    .txd        (txd_a),
    .busy       (busy_a),
    .frame_done (done_a),
    .state_o    (state_a)
  );

  serial_transmit #(.CLKS_PER_BIT(16), .STOP_BITS(2)) u_b (
    .clk        (clk),
    .rst        (rst),
    .up         (if_b),
    .txd        (txd_b),
    .busy       (busy_b),
    .frame_done (done_b),
    .state_o    (state_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected line level k cycles after the start edge.
  function automatic logic exp_bit(input logic [7:0] b, input int k, input int cpb);
    int j;
    j = k / cpb;
    if (j == 0) return 1'b0;
    else if (j <= 8) return b[8-j];
    else return 1'b1;
  endfunction

  // Checks cycles k0..k1 of a frame; returns positioned after cycle k1+1's edge.
  task automatic check_frame(input bit sel, input logic [7:0] b, input int k0, input int k1,
                             input logic exp_rdy, input string tag);
    int cpb;
    cpb = sel ? 16 : 4;
    for (int k = k0; k <= k1; k++) begin
      check($sformatf("%s_txd_k%0d", tag, k), sel ? txd_b : txd_a, exp_bit(b, k, cpb));
      check($sformatf("%s_busy_k%0d", tag, k), sel ? busy_b : busy_a, 1);
      check($sformatf("%s_rdy_k%0d", tag, k), sel ? if_b.data_ready : if_a.data_ready, exp_rdy);
      if (k > 0) check($sformatf("%s_done_k%0d", tag, k), sel ? done_b : done_a, 0);
      tick(1);
    end
  endtask

  logic [7:0] t6_bytes [4];
  logic [7:0] shreg;
  logic [7:0] exp_byte;
  int idx, phase, nfr, ferr, last_start;
  logic acc;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    if_a.data_valid = 1'b0; if_a.data_in = 8'h00;
    if_b.data_valid = 1'b0; if_b.data_in = 8'h00;

    // reset state, before any clock edge
    #1 rst = 1'b1;
    #1;
    check("rst_txd", txd_a, 1);
    check("rst_rdy", if_a.data_ready, 1);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_state", state_a, 0);
    check("rst_txd_b", txd_b, 1);
    check("rst_rdy_b", if_b.data_ready, 1);
    tick(1);
    rst = 1'b0;
    tick(1);

    // 1: single frame 0xA5
    if_a.data_valid = 1'b1; if_a.data_in = 8'hA5;
    tick(1);
    if_a.data_valid = 1'b0;
    check("t1_rdy_after_accept", if_a.data_ready, 0);
    check("t1_txd_idle", txd_a, 1);
    check("t1_busy_idle", busy_a, 0);
    tick(1);
    check_frame(1'b0, 8'hA5, 0, 39, 1'b1, "t1");
    check("t1_done", done_a, 1);
    check("t1_busy_end", busy_a, 0);
    check("t1_txd_end", txd_a, 1);
    check("t1_state_end", state_a, 0);
    tick(1);
    check("t1_done_clear", done_a, 0);

    // 2: 0x3C then 0xC3 queued during frame 1, back to back
    if_a.data_valid = 1'b1; if_a.data_in = 8'h3C;
    tick(1);
    if_a.data_valid = 1'b0;
    tick(1);
    check("t2_start_txd", txd_a, 0);
    check("t2_start_rdy", if_a.data_ready, 1);
    if_a.data_valid = 1'b1; if_a.data_in = 8'hC3;
    tick(1);
    if_a.data_valid = 1'b0; if_a.data_in = 8'h00;
    check_frame(1'b0, 8'h3C, 1, 39, 1'b0, "t2a");
    check("t2_done1", done_a, 1);
    check("t2_nogap_txd", txd_a, 0);
    check("t2_busy_mid", busy_a, 1);
    check("t2_rdy_after_xfer", if_a.data_ready, 1);
    check_frame(1'b0, 8'hC3, 0, 39, 1'b1, "t2b");
    check("t2_done2", done_a, 1);
    check("t2_busy_end", busy_a, 0);

    // 3: data_in changes while stalled; only the accepting-edge value is sent
    tick(2);
    if_a.data_valid = 1'b1; if_a.data_in = 8'h66;
    tick(1);
    if_a.data_valid = 1'b0;
    tick(1);
    if_a.data_valid = 1'b1; if_a.data_in = 8'h77;
    tick(1);
    if_a.data_in = 8'h11;
    check_frame(1'b0, 8'h66, 1, 19, 1'b0, "t3a");
    if_a.data_in = 8'h22;
    check_frame(1'b0, 8'h66, 20, 39, 1'b0, "t3b");
    check("t3_done1", done_a, 1);
    check("t3_nogap1", txd_a, 0);
    check("t3_rdy_rise", if_a.data_ready, 1);
    tick(1);
    if_a.data_valid = 1'b0; if_a.data_in = 8'h00;
    check_frame(1'b0, 8'h77, 1, 39, 1'b0, "t3c");
    check("t3_done2", done_a, 1);
    check("t3_nogap2", txd_a, 0);
    check_frame(1'b0, 8'h22, 0, 39, 1'b1, "t3d");
    check("t3_done3", done_a, 1);
    check("t3_busy_end", busy_a, 0);

    // 4: async reset during data bit 3 with a byte held, then a clean frame
    tick(2);
    if_a.data_valid = 1'b1; if_a.data_in = 8'hC3;
    tick(1);
    if_a.data_valid = 1'b0;
    tick(1);
    if_a.data_valid = 1'b1; if_a.data_in = 8'h33;
    tick(1);
    if_a.data_valid = 1'b0; if_a.data_in = 8'h00;
    check_frame(1'b0, 8'hC3, 1, 17, 1'b0, "t4a");
    check("t4_pre_rst_txd", txd_a, 0);
    #3 rst = 1'b1;
    #1;
    check("t4_rst_txd", txd_a, 1);
    check("t4_rst_busy", busy_a, 0);
    check("t4_rst_rdy", if_a.data_ready, 1);
    check("t4_rst_done", done_a, 0);
    check("t4_rst_state", state_a, 0);
    tick(2);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check($sformatf("t4_idle_txd_%0d", i), txd_a, 1);
      check($sformatf("t4_idle_busy_%0d", i), busy_a, 0);
    end
    if_a.data_valid = 1'b1; if_a.data_in = 8'h5A;
    tick(1);
    if_a.data_valid = 1'b0; if_a.data_in = 8'h00;
    tick(1);
    check_frame(1'b0, 8'h5A, 0, 39, 1'b1, "t4c");
    check("t4_done", done_a, 1);
    check("t4_busy_end", busy_a, 0);

    // 5: two stop bits at 16 clk/bit, 0xFF: 176-cycle frame
    tick(2);
    if_b.data_valid = 1'b1; if_b.data_in = 8'hFF;
    tick(1);
    if_b.data_valid = 1'b0; if_b.data_in = 8'h00;
    tick(1);
    check_frame(1'b1, 8'hFF, 0, 175, 1'b1, "t5");
    check("t5_done", done_b, 1);
    check("t5_busy_end", busy_b, 0);
    check("t5_txd_end", txd_b, 1);
    tick(1);
    check("t5_done_clear", done_b, 0);

    // 6: mid-bit sampler decoding four back-to-back frames
    tick(2);
    t6_bytes[0] = 8'h00; t6_bytes[1] = 8'hFF; t6_bytes[2] = 8'h80; t6_bytes[3] = 8'h01;
    idx = 0; phase = -1; nfr = 0; ferr = 0; last_start = 0; shreg = 8'h00;
    if_a.data_valid = 1'b1; if_a.data_in = t6_bytes[0];
    for (int c = 0; c < 200; c++) begin
      acc = if_a.data_valid && if_a.data_ready;
      tick(1);
      if (acc) begin
        exp_q.push_back(if_a.data_in);
        idx++;
      end
      if (idx < 4) begin
        if_a.data_valid = 1'b1; if_a.data_in = t6_bytes[idx];
      end else begin
        if_a.data_valid = 1'b0; if_a.data_in = 8'h00;
      end
      if (phase < 0 && txd_a == 1'b0) begin
        phase = 0;
        if (nfr > 0) check($sformatf("t6_frame_spacing_%0d", nfr), c - last_start, 40);
        last_start = c;
      end
      if (phase >= 0) begin
        if (phase % 4 == 2 && phase / 4 == 9) begin
          if (txd_a !== 1'b1) ferr++;
          check($sformatf("t6_q_nonempty_%0d", nfr), exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            exp_byte = exp_q.pop_front();
            check($sformatf("t6_byte_%0d", nfr), shreg, exp_byte);
          end
          nfr++;
          phase = -1;
        end else begin
          if (phase % 4 == 2) begin
            if (phase / 4 == 0) begin
              if (txd_a !== 1'b0) ferr++;
            end else begin
              shreg = {shreg[6:0], txd_a};
            end
          end
          phase++;
        end
      end
    end
    check("t6_frames", nfr, 4);
    check("t6_framing_errors", ferr, 0);
    check("t6_queue_drained", exp_q.size(), 0);
    check("t6_idle_end", busy_a, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
